signed_unsigned_arithmetic: RTL and testbench
=============================================

Name: signed_unsigned_arithmetic

Overview:
- Registered multiply-add unit: o_answer = i_a * i_b + i_c.
- Operands are treated as unsigned (i_mode=0) or two's-complement signed (i_mode=1).
- Two-stage pipeline with valid qualifier; used as a small arithmetic primitive inside datapaths needing selectable signedness.

Parameters:
- WIDTH, 4, operand width of i_a/i_b/i_c; result width is 2*WIDTH (WIDTH >= 2).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operands/mode valid this cycle.
- i_mode  input  1  0 = unsigned, 1 = signed (two's complement).
- i_a  input  WIDTH  multiplicand.
- i_b  input  WIDTH  multiplier.
- i_c  input  WIDTH  addend.
- o_valid  output  1  o_answer holds a new result this cycle.
- o_answer  output  2*WIDTH  result of i_a*i_b+i_c in the selected mode.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst); sampled only on the rising edge of i_clk.
- Reset: o_answer=0, o_valid=0, all internal pipeline registers and stage valids cleared. Reset has priority over i_valid in the same cycle.
- Reset mid-operation: in-flight results are discarded; no o_valid pulse for operands accepted before reset.
- Stage 1 (edge N, when i_valid=1):
  - Register the 2*WIDTH product of i_a and i_b.
  - Register i_c extended to 2*WIDTH: zero-extended if i_mode=0, sign-extended if i_mode=1.
  - Register i_mode.
  - Product rules: i_mode=0 treats both operands as unsigned; i_mode=1 treats both as signed, full 2*WIDTH signed product.
- Stage 2 (edge N+1): o_answer <= product + extended c, truncated to 2*WIDTH bits; o_valid <= stage-1 valid.
- Latency: result of operands presented with i_valid at edge N appears at edge N+1, with o_valid high for exactly one cycle per accepted input.
- Throughput: one operation per cycle. Back-to-back valids produce back-to-back results in order.
- Mode is per-transaction: i_mode is captured with its operands, so mode may change every cycle.
- i_valid=0:
  - Stage-1 data registers hold their values; stage valid goes 0.
  - When stage valid is 0, o_answer holds its last value and o_valid=0.
- Overflow: none possible for any WIDTH >= 2.
  - Unsigned max = 2^(2W) - 2^W.
  - Signed range lies within [-2^(2W-1), 2^(2W-1)-1].
  - No saturation or overflow flag is required.
- o_answer in signed mode is a two's-complement 2*WIDTH value.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert i_rst for 2 cycles with i_valid=1 and nonzero operands -> o_answer=0, o_valid=0 throughout and one cycle after release.
- Unsigned: i_mode=0, i_a=4'b0010 (2), i_b=4'b0011 (3), i_c=4'b0100 (4), i_valid=1 -> two edges later o_answer=8'd10, o_valid=1 for one cycle.
- Signed: i_mode=1, i_a=4'b1111 (-1), i_b=4'b1110 (-2), i_c=4'b0011 (3) -> o_answer=8'd5. Same inputs with i_mode=0 -> 15*14+3 = 8'd213.
- Extremes:
  - Unsigned 15*15+15 -> 8'd240.
  - Signed (-8)*(-8)+7 -> 8'd71.
  - Signed (-8)*7+(-8) -> -64 = 8'hC0.
  - Signed 0*0+(-1) -> 8'hFF (sign-extension of c).
- Back-to-back with mode toggling: 4 consecutive valids alternating i_mode with the vectors above -> 4 consecutive o_valid cycles with results in order. A gap in i_valid -> o_valid=0 and o_answer held.
- Reset mid-pipeline: assert i_rst one cycle after a valid input -> no o_valid for that input, o_answer=0.

Source files
------------

// File: rtl/signed_unsigned_arithmetic.sv
// signed_unsigned_arithmetic: two-stage registered a*b+c with per-transaction signedness
module signed_unsigned_arithmetic #(
    parameter int WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_mode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [WIDTH-1:0]   i_c,
    output logic               o_valid,
    output logic [2*WIDTH-1:0] o_answer
);
    logic [2*WIDTH-1:0] a_ext, b_ext, c_ext, prod, addend;
    logic               stage_valid;
    // Extend operands to full width; low 2W bits of the extended product are the exact signed or unsigned product
    always_comb begin
        a_ext = i_mode ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
        b_ext = i_mode ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
        c_ext = i_mode ? {{WIDTH{i_c[WIDTH-1]}}, i_c} : {{WIDTH{1'b0}}, i_c};
    end
    // Stage 1: capture product and extended addend; data holds while idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod        <= '0;
            addend      <= '0;
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= i_valid;
            if (i_valid) begin
                prod   <= a_ext * b_ext;
                addend <= c_ext;
            end
        end
    end
    // Stage 2: accumulate and present result; answer holds when no new data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_answer <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= stage_valid;
            if (stage_valid) o_answer <= prod + addend;
        end
    end
endmodule

// File: tb/tb_signed_unsigned_arithmetic.sv
// tb_signed_unsigned_arithmetic: directed vector bench for the multiply-add pipeline
module tb_signed_unsigned_arithmetic;
    logic       clk = 1'b0;
    logic       rst, valid, mode, o_valid;
    logic [3:0] a, b, c;
    logic [7:0] answer;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        logic       mode;
        logic [3:0] a, b, c;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    signed_unsigned_arithmetic #(.WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mode(mode),
        .i_a(a), .i_b(b), .i_c(c), .o_valid(o_valid), .o_answer(answer)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input vec_t t);
        valid = v;
        mode  = t.mode;
        a     = t.a;
        b     = t.b;
        c     = t.c;
    endtask

    task automatic check(input string name, input logic exp_v, input logic [7:0] exp_ans);
        n_vec++;
        if (o_valid !== exp_v || answer !== exp_ans) begin
            n_err++;
            $display("FAIL %s: got valid=%b answer=%h, want valid=%b answer=%h",
                     name, o_valid, answer, exp_v, exp_ans);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'd2,  4'd3,  4'd4,  8'd10};
        vecs[1] = '{1'b1, 4'hF,  4'hE,  4'd3,  8'd5};
        vecs[2] = '{1'b0, 4'hF,  4'hE,  4'd3,  8'd213};
        vecs[3] = '{1'b0, 4'hF,  4'hF,  4'hF,  8'd240};
        vecs[4] = '{1'b1, 4'h8,  4'h8,  4'd7,  8'd71};
        vecs[5] = '{1'b1, 4'h8,  4'd7,  4'h8,  8'hC0};
        vecs[6] = '{1'b1, 4'd0,  4'd0,  4'hF,  8'hFF};
        vecs[7] = '{1'b0, 4'd0,  4'd0,  4'hF,  8'h0F};
        vecs[8] = '{1'b1, 4'd7,  4'd7,  4'd7,  8'd56};
        vecs[9] = '{1'b1, 4'd2,  4'hE,  4'd1,  8'hFD};

        rst = 1'b1;
        drive(1'b1, vecs[3]);
        step();
        check("reset_c1", 1'b0, 8'h00);
        step();
        check("reset_c2", 1'b0, 8'h00);
        rst   = 1'b0;
        valid = 1'b0;
        step();
        check("reset_release", 1'b0, 8'h00);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i]);
            step();
            drive(1'b0, vecs[(i + 3) % 10]);
            step();
            check($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
            step();
            check($sformatf("vec%0d_hold", i), 1'b0, vecs[i].exp);
        end

        begin
            int seq[4] = '{0, 1, 2, 4};
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, vecs[seq[k]]);
                step();
                if (k > 0) check($sformatf("b2b%0d", k - 1), 1'b1, vecs[seq[k - 1]].exp);
            end
            drive(1'b0, vecs[6]);
            step();
            check("b2b3", 1'b1, vecs[4].exp);
            step();
            check("gap_hold1", 1'b0, vecs[4].exp);
            step();
            check("gap_hold2", 1'b0, vecs[4].exp);
        end

        drive(1'b1, vecs[0]);
        step();
        valid = 1'b0;
        rst   = 1'b1;
        step();
        check("midrst_edge", 1'b0, 8'h00);
        rst = 1'b0;
        step();
        check("midrst_after", 1'b0, 8'h00);
        step();
        check("midrst_after2", 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
